// File: rtl/div_scheduler.sv
// Arbitrates one shared sequential divider between N_REQ requesters (focus priority + round robin).
// Optional WAIT timeout abort is enabled by defining DIV_SCHED_TIMEOUT_EN.
module div_scheduler #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned W       = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                            Clock,
    input  logic                            Reset,
    input  logic [N_REQ-1:0]                req,
    input  logic [N_REQ*W-1:0]              dividend,
    input  logic [N_REQ*W-1:0]              divisor,
    input  logic                            focus_en,
    input  logic [$clog2(N_REQ)-1:0]        focus_id,
    output logic                            div_start,
    output logic [W-1:0]                    div_a,
    output logic [W-1:0]                    div_b,
    input  logic                            div_done,
    input  logic [W-1:0]                    div_q,
    output logic [N_REQ-1:0]                ack,
    output logic [W-1:0]                    result,
    output logic                            err
);

    localparam int unsigned GW = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        ACK
    } state_t;

    state_t          state;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   win;
    logic [GW-1:0]   rr;
    logic [W-1:0]    a_arr [N_REQ];
    logic [W-1:0]    b_arr [N_REQ];

`ifdef DIV_SCHED_TIMEOUT_EN
    localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0]   cnt;
`endif

    // Unpack the flat operand buses per requester.
    always_comb begin
        for (int i = 0; i < int'(N_REQ); i++) begin
            a_arr[i] = dividend[i*W +: W];
            b_arr[i] = divisor[i*W +: W];
        end
    end

    // Winner: focus requester if eligible, else first set bit above last_grant (downward loop keeps the nearest).
    always_comb begin
        win = '0;
        rr  = '0;
        for (int k = int'(N_REQ); k >= 1; k--) begin
            rr = GW'((32'(last_grant) + 32'(k)) % N_REQ);
            if (req[rr]) begin
                win = rr;
            end
        end
        if (focus_en && (32'(focus_id) < N_REQ) && req[focus_id]) begin
            win = focus_id;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(N_REQ - 1);
            div_start  <= 1'b0;
            div_a      <= '0;
            div_b      <= '0;
            ack        <= '0;
            result     <= '0;
            err        <= 1'b0;
`ifdef DIV_SCHED_TIMEOUT_EN
            cnt        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ack <= '0;
                    if (|req) begin
                        grant <= win;
                        div_a <= a_arr[win];
                        div_b <= b_arr[win];
                        if (b_arr[win] == '0) begin
                            // Divide by zero never reaches the divider.
                            result <= '1;
                            err    <= 1'b1;
                            ack    <= ONE_HOT0 << win;
                            state  <= ACK;
                        end else begin
                            div_start <= 1'b1;
                            state     <= START;
                        end
                    end
                end
                START: begin
                    div_start <= 1'b0;
`ifdef DIV_SCHED_TIMEOUT_EN
                    cnt       <= '0;
`endif
                    state     <= WAIT;
                end
                WAIT: begin
                    if (div_done) begin
                        result <= div_q;
                        err    <= 1'b0;
                        ack    <= ONE_HOT0 << grant;
                        state  <= ACK;
                    end
`ifdef DIV_SCHED_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT - 1)) begin
                        result <= '1;
                        err    <= 1'b1;
                        ack    <= ONE_HOT0 << grant;
                        state  <= ACK;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
`endif
                end
                ACK: begin
                    ack        <= '0;
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_scheduler.sv
// Self-checking bench for div_scheduler: the bench plays requesters and the divider against a rule-level model.
module tb_div_scheduler;

    localparam int N  = 4;
    localparam int WD = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*WD-1:0] dividend = '0;
    logic [N*WD-1:0] divisor = '0;
    logic            focus_en = 1'b0;
    logic [1:0]      focus_id = '0;
    logic            div_start;
    logic [WD-1:0]   div_a;
    logic [WD-1:0]   div_b;
    logic            div_done = 1'b0;
    logic [WD-1:0]   div_q = '0;
    logic [N-1:0]    ack;
    logic [WD-1:0]   result;
    logic            err;

    int n_vec = 0;
    int n_err = 0;
    int mlg   = N - 1;
    int last_w;
    logic [WD-1:0] ma [N];
    logic [WD-1:0] mb [N];

    div_scheduler #(.N_REQ(N), .W(WD), .TIMEOUT(8)) dut (
        .Clock(clk), .Reset(rst), .req(req), .dividend(dividend), .divisor(divisor),
        .focus_en(focus_en), .focus_id(focus_id), .div_start(div_start), .div_a(div_a),
        .div_b(div_b), .div_done(div_done), .div_q(div_q), .ack(ack), .result(result), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [WD-1:0] a, input logic [WD-1:0] b);
        ma[i] = a;
        mb[i] = b;
        dividend[i*WD +: WD] = a;
        divisor[i*WD +: WD]  = b;
    endtask

    function automatic int pick_winner();
        if (focus_en && req[focus_id]) return int'(focus_id);
        for (int k = 1; k <= N; k++) begin
            if (req[(mlg + k) % N]) return (mlg + k) % N;
        end
        return -1;
    endfunction

    // Called in an IDLE cycle with req already driven; serves exactly one winner.
    task automatic serve_one(input int dly, input bit stray);
        int w;
        logic [WD-1:0] ea, eb, eq;
        w  = pick_winner();
        ea = ma[w];
        eb = mb[w];
        step();
        if (eb == '0) begin
            check("dz_ack", 32'(ack), 32'(1) << w);
            check("dz_result", 32'(result), 32'hFFFF);
            check("dz_err", 32'(err), 32'd1);
            check("dz_start", 32'(div_start), 32'd0);
        end else begin
            eq = ea / eb;
            check("start_pulse", 32'(div_start), 32'd1);
            check("start_noack", 32'(ack), 32'd0);
            if (stray) div_done = 1'b1;
            div_q = 16'($urandom);
            set_ops(w, 16'($urandom), 16'($urandom_range(1, 65535)));
            step();
            div_done = 1'b0;
            check("wait_nostart", 32'(div_start), 32'd0);
            check("wait_div_a", 32'(div_a), 32'(ea));
            check("wait_div_b", 32'(div_b), 32'(eb));
            for (int j = 0; j < dly; j++) begin
                step();
                check("wait_noack", 32'(ack), 32'd0);
            end
            div_done = 1'b1;
            div_q    = eq;
            step();
            div_done = 1'b0;
            div_q    = 16'($urandom);
            check("ack_onehot", 32'(ack), 32'(1) << w);
            check("ack_result", 32'(result), 32'(eq));
            check("ack_err", 32'(err), 32'd0);
        end
        req[w] = 1'b0;
        mlg    = w;
        last_w = w;
        step();
        check("idle_noack", 32'(ack), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) set_ops(i, 16'd0, 16'd1);

        // Reset values.
        step();
        step();
        check("rst_start", 32'(div_start), 32'd0);
        check("rst_a", 32'(div_a), 32'd0);
        check("rst_b", 32'(div_b), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        mlg = N - 1;
        step();

        // Single request, done 3 cycles after start.
        set_ops(1, 16'd1000, 16'd8);
        req = 4'b0010;
        serve_one(2, 1'b0);
        check("single_result", 32'(result), 32'd125);

        // Round robin from reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        mlg = N - 1;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N; i++) set_ops(i, 16'($urandom), 16'($urandom_range(1, 300)));
            req = 4'b1111;
            serve_one(k % 3, 1'b0);
            check("rr_order", 32'(last_w), 32'(k % N));
        end
        req = '0;
        step();

        // Focus priority: 2 first, then 0.
        set_ops(0, 16'd500, 16'd5);
        set_ops(2, 16'd900, 16'd3);
        req      = 4'b0101;
        focus_en = 1'b1;
        focus_id = 2'd2;
        serve_one(1, 1'b1);
        check("focus_first", 32'(last_w), 32'd2);
        serve_one(0, 1'b0);
        check("focus_second", 32'(last_w), 32'd0);
        focus_en = 1'b0;

        // Divide by zero.
        set_ops(3, 16'd77, 16'd0);
        req = 4'b1000;
        serve_one(0, 1'b0);

        // Stray done in IDLE.
        div_done = 1'b1;
        step();
        div_done = 1'b0;
        check("stray_idle_ack", 32'(ack), 32'd0);
        check("stray_idle_start", 32'(div_start), 32'd0);

        // Reset during WAIT, then a late done.
        set_ops(0, 16'd40, 16'd4);
        req = 4'b0001;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = '0;
        mlg = N - 1;
        check("mid_rst_ack", 32'(ack), 32'd0);
        check("mid_rst_start", 32'(div_start), 32'd0);
        check("mid_rst_a", 32'(div_a), 32'd0);
        div_done = 1'b1;
        div_q    = 16'h1234;
        step();
        div_done = 1'b0;
        check("late_done_ack", 32'(ack), 32'd0);
        step();
        check("late_done_ack2", 32'(ack), 32'd0);
        check("late_done_result", 32'(result), 32'd0);
        set_ops(2, 16'd81, 16'd9);
        req = 4'b0100;
        serve_one(1, 1'b0);

        // Divider never answers: timeout abort or indefinite hold.
        set_ops(1, 16'd10, 16'd2);
        req = 4'b0010;
        step();
        check("hang_start", 32'(div_start), 32'd1);
        step();
`ifdef DIV_SCHED_TIMEOUT_EN
        for (int j = 0; j < 7; j++) begin
            step();
            check("to_noack", 32'(ack), 32'd0);
        end
        step();
        check("to_ack", 32'(ack), 32'b0010);
        check("to_result", 32'(result), 32'hFFFF);
        check("to_err", 32'(err), 32'd1);
`else
        for (int j = 0; j < 20; j++) begin
            step();
            check("hold_noack", 32'(ack), 32'd0);
        end
        div_done = 1'b1;
        div_q    = 16'd5;
        step();
        div_done = 1'b0;
        check("hold_ack", 32'(ack), 32'b0010);
        check("hold_result", 32'(result), 32'd5);
`endif
        req = '0;
        mlg = 1;
        step();

        // Randomized traffic against the model.
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < N; i++) begin
                set_ops(i, 16'($urandom),
                        ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535)));
            end
            req      = req | 4'($urandom_range(1, 15));
            focus_en = 1'($urandom_range(0, 1));
            focus_id = 2'($urandom_range(0, 3));
            serve_one(int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
        end
        while (req != '0) serve_one(1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div_scheduler.md
# div_scheduler

Arbitrates one shared sequential divider between the bicycle computer's calculation requesters: speed, cadence, average speed and calorie. Each requester supplies its own operands. The scheduler grants one requester at a time, runs a start/done handshake with the divider, and returns the quotient with a one-cycle acknowledge. The quantity currently on the display can be given priority, so the visible value refreshes first.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `W`, default 16: dividend, divisor and quotient width.
- `TIMEOUT`, default 255: maximum WAIT cycles before abort. Used only with `DIV_SCHED_TIMEOUT_EN`.

- `Clock`  in  1: system clock, rising edge.
- `Reset`  in  1: synchronous, active-high reset.
- `req`  in  N_REQ: level request per requester, held until that requester's `ack`.
- `dividend`  in  N_REQ*W: requester i's dividend at `[i*W +: W]`.
- `divisor`  in  N_REQ*W: requester i's divisor at `[i*W +: W]`.
- `focus_en`  in  1: enables priority for `focus_id`.
- `focus_id`  in  $clog2(N_REQ): index of the displayed requester.
- `div_start`  out  1: one-cycle start pulse to the divider.
- `div_a`  out  W: dividend to the divider.
- `div_b`  out  W: divisor to the divider.
- `div_done`  in  1: divider completion pulse.
- `div_q`  in  W: divider quotient, valid with `div_done`.
- `ack`  out  N_REQ: one-hot, one-cycle completion to the granted requester.
- `result`  out  W: quotient, valid while `ack` is nonzero; held otherwise.
- `err`  out  1: divide-by-zero or timeout, valid with `ack`.

## Operation
- States: IDLE, START, WAIT, ACK.
- **IDLE, no request:** remain in IDLE while `req` is all zero.
- **IDLE, request present:** pick a winner, register it as `grant`, and latch its operands into `div_a`/`div_b`.
- **Winner selection:**
  - If `focus_en`=1, `focus_id` < N_REQ and `req[focus_id]`=1, the winner is `focus_id`.
  - Otherwise the winner is round-robin: the first set `req` bit searching upward from `last_grant+1`, wrapping modulo N_REQ.
- **Divide by zero:** if the latched divisor is 0, go directly to ACK with `result` = all ones and `err`=1. The divider is not started.
- **Nonzero divisor:** go to START.
- **START:** `div_start`=1 for exactly this cycle, then go to WAIT.
- **WAIT:** when `div_done`=1, capture `div_q` into `result`, set `err`=0, and go to ACK.
- **ACK:** `ack[grant]`=1 for exactly this cycle. Set `last_grant`=`grant`, then go to IDLE.
- **Operand stability:** `div_a`/`div_b` are stable from START through WAIT. Requester operand changes after the grant are ignored.
- **Requester rule:** deassert `req` on the clock edge that ends the `ack` cycle. Its `req` is therefore low in the following IDLE cycle.
- **Stray `div_done`:** ignored in IDLE, START and ACK.
- **Focus bypasses fairness:** `focus_en` with a continuously requesting focus requester starves the others. This is intended; the display only focuses one quantity at a time.
- **Reset values:**
  - state = IDLE, `last_grant` = N_REQ-1, so the first round-robin search starts at 0.
  - `div_start`, `div_a`, `div_b`, `ack`, `result` and `err` are all 0.
- **Reset mid-operation:** any state returns to IDLE with no `ack`. A later `div_done` is ignored.

## Timing
- Request high in IDLE cycle c:
  - `div_start` is high in cycle c+1.
  - WAIT starts in cycle c+2.
  - If `div_done` is seen in cycle d ≥ c+2, `ack` is high in cycle d+1.
- Divide by zero: `ack` is high in cycle c+1 and `div_start` is never asserted.
- Minimum spacing between consecutive acks is 1 IDLE cycle.
- All outputs are registered or are Moore decodes of state. There are no combinational paths from `req` or `div_done` to outputs.

## Configuration
- **`DIV_SCHED_TIMEOUT_EN` defined:**
  - An 8-bit-or-wider counter clears in START and increments each WAIT cycle.
  - When the counter reaches `TIMEOUT` without `div_done`, go to ACK with `result` = all ones and `err`=1.
  - If `div_done` and the timeout occur in the same cycle, `div_done` wins (`err`=0).
- **Undefined:** there is no counter and WAIT holds indefinitely until `div_done`.

## Test plan
1. **Single request:** `req`=0010, dividend 1000, divisor 8, divider done 3 cycles after start -> `ack`=0010 for one cycle, `result`=125, `err`=0, with `ack` 1 cycle after done.
2. **Round-robin fairness:** after reset, `req`=1111 re-raised after each ack, `focus_en`=0 -> grants 0,1,2,3,0 in order.
3. **Focus priority:** `req`=0101 raised together, `focus_en`=1, `focus_id`=2 -> requester 2 is acked first, then requester 0.
4. **Divide by zero:** `req[3]` with divisor 0 -> `ack`=1000 in the cycle after the request, `result`=16'hFFFF, `err`=1, `div_start` stays 0 throughout.
5. **Reset during WAIT:** `Reset` pulsed in WAIT, then a `div_done` pulse -> no `ack`, state IDLE. A following request is served normally with a new `div_start`.
6. **Timeout:** with `DIV_SCHED_TIMEOUT_EN` and `TIMEOUT`=8, the divider never signals done -> `ack` after 8 WAIT cycles, `result`=16'hFFFF, `err`=1.
